winner_loser_trigger_gen: RTL and testbench

//  Producer side of the flag-counter trigger interface. Watches the game counter value and

---
 rtl/winner_loser_trigger_gen.sv | 95 +++++++++
 tb/tb_winner_loser_trigger_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/winner_loser_trigger_gen.sv
// Turns game-counter boundary hits into one-cycle winner/loser triggers and latches the game result.
// Outputs are registered one cycle after sampling; there is no backpressure, so pulses are never held.
module winner_loser_trigger_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  input  logic             winner_gameover,
  input  logic             loser_gameover,
  output logic             winner,
  output logic             loser,
  output logic             gameover,
  output logic [1:0]       who
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HOLD_HI = 2'd1,
    HOLD_LO = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  state_t     state_q, state_d;
  logic       winner_q, winner_d;
  logic       loser_q, loser_d;
  logic       gameover_q, gameover_d;
  logic [1:0] who_q, who_d;

  logic at_max;
  logic at_zero;
  logic end_req;

  assign at_max  = (count == CNT_MAX);
  assign at_zero = (count == CNT_ZERO);
  assign end_req = winner_gameover | loser_gameover;

  always_comb begin
    state_d    = state_q;
    winner_d   = 1'b0;
    loser_d    = 1'b0;
    gameover_d = gameover_q;
    who_d      = who_q;

    // A game-over request outranks any boundary seen in the same cycle.
    if (state_q != DONE && end_req) begin
      state_d    = DONE;
      gameover_d = 1'b1;
      who_d      = {loser_gameover, winner_gameover};
    end else if (enable) begin
      case (state_q)
        ARMED: begin
          if (at_max) begin
            winner_d = 1'b1;
            state_d  = HOLD_HI;
          end else if (at_zero) begin
            loser_d = 1'b1;
            state_d = HOLD_LO;
          end
        end
        HOLD_HI: if (!at_max)  state_d = ARMED;
        HOLD_LO: if (!at_zero) state_d = ARMED;
        DONE:    state_d = DONE;
        default: state_d = HOLD_LO;
      endcase
    end
  end

  // Reset lands in HOLD_LO so the counter's own reset value of 0 does not fire loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD_LO;
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      loser_q    <= loser_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
    end
  end

  assign winner   = winner_q;
  assign loser    = loser_q;
  assign gameover = gameover_q;
  assign who      = who_q;

endmodule

// File: tb/tb_winner_loser_trigger_gen.sv
// Directed bench for winner_loser_trigger_gen with a cycle-level reference model and literal spot checks.
module tb_winner_loser_trigger_gen;

  localparam int WIDTH = 4;
  localparam int MAX   = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             winner_gameover;
  logic             loser_gameover;
  logic             winner;
  logic             loser;
  logic             gameover;
  logic [1:0]       who;

  int vectors     = 0;
  int miscompares = 0;

  winner_loser_trigger_gen #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .count           (count),
    .winner_gameover (winner_gameover),
    .loser_gameover  (loser_gameover),
    .winner          (winner),
    .loser           (loser),
    .gameover        (gameover),
    .who             (who)
  );

  always #20 clk = ~clk;

  // Reference: hold_val is the boundary value last reported (-1 when free to report again).
  int         hold_val;
  bit         m_done;
  bit         m_winner;
  bit         m_loser;
  logic [1:0] m_who;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_val = 0;
      m_done   = 0;
      m_winner = 0;
      m_loser  = 0;
      m_who    = 2'b00;
    end else begin
      m_winner = 0;
      m_loser  = 0;
      if (!m_done) begin
        if (winner_gameover || loser_gameover) begin
          m_done = 1;
          m_who  = {loser_gameover, winner_gameover};
        end else if (enable) begin
          if (hold_val >= 0) begin
            if (int'(count) != hold_val) hold_val = -1;
          end else if (int'(count) == MAX) begin
            m_winner = 1;
            hold_val = MAX;
          end else if (int'(count) == 0) begin
            m_loser  = 1;
            hold_val = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_winner",   {1'b0, winner},   {1'b0, m_winner});
    chk("model_loser",    {1'b0, loser},    {1'b0, m_loser});
    chk("model_gameover", {1'b0, gameover}, {1'b0, m_done});
    chk("model_who",      who,              m_who);
  end

  // Drive one sample, let the DUT take it, and settle just after the edge.
  task automatic apply(input logic en, input int c, input logic wg, input logic lg);
    enable          = en;
    count           = c[WIDTH-1:0];
    winner_gameover = wg;
    loser_gameover  = lg;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    #3 rst = 1'b1;
    #1;
    chk("rst_winner",   {1'b0, winner},   2'd0);
    chk("rst_loser",    {1'b0, loser},    2'd0);
    chk("rst_gameover", {1'b0, gameover}, 2'd0);
    chk("rst_who",      who,              2'd0);
    #6 rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    enable          = 1'b1;
    count           = '0;
    winner_gameover = 1'b0;
    loser_gameover  = 1'b0;
    #30;
    chk("reset_winner",   {1'b0, winner},   2'd0);
    chk("reset_loser",    {1'b0, loser},    2'd0);
    chk("reset_gameover", {1'b0, gameover}, 2'd0);
    chk("reset_who",      who,              2'd0);
    #20 rst = 1'b0;

    // 1: holding 0 out of reset must not fire loser
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 0, 0);
      chk("t1_no_loser", {1'b0, loser}, 2'd0);
    end

    // 2: ramp to MAX, then hold
    for (int c = 1; c <= MAX; c++) begin
      apply(1, c, 0, 0);
      chk("t2_ramp_winner", {1'b0, winner}, (c == MAX) ? 2'd1 : 2'd0);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1, MAX, 0, 0);
      chk("t2_hold_winner", {1'b0, winner}, 2'd0);
    end

    // 3: dip and return re-fires winner
    apply(1, 14, 0, 0);
    chk("t3_dip_winner", {1'b0, winner}, 2'd0);
    apply(1, MAX, 0, 0);
    chk("t3_rewin", {1'b0, winner}, 2'd1);

    // 4: direct MAX -> 0 load
    apply(1, MAX, 0, 0);
    apply(1, 0, 0, 0);
    chk("t4_first0_loser", {1'b0, loser}, 2'd0);
    apply(1, 0, 0, 0);
    chk("t4_second0_loser", {1'b0, loser}, 2'd1);

    // enable low freezes detection
    apply(1, 3, 0, 0);
    apply(0, 0, 0, 0);
    chk("frozen_loser", {1'b0, loser}, 2'd0);
    apply(1, 0, 0, 0);
    chk("unfrozen_loser", {1'b0, loser}, 2'd1);

    // 5: gameover beats a boundary in the same cycle
    apply(1, 4, 0, 0);
    apply(1, 0, 1, 0);
    chk("t5_loser", {1'b0, loser}, 2'd0);
    chk("t5_gameover", {1'b0, gameover}, 2'd1);
    chk("t5_who", who, 2'b01);
    apply(1, MAX, 0, 0);
    apply(1, 0, 0, 1);
    apply(1, 7, 0, 0);
    apply(1, MAX, 0, 0);
    chk("t5_done_winner", {1'b0, winner}, 2'd0);
    chk("t5_done_who", who, 2'b01);
    chk("t5_done_gameover", {1'b0, gameover}, 2'd1);

    // 6: reset out of DONE, then a tie
    pulse_reset();
    apply(1, 2, 0, 0);
    apply(1, 3, 1, 1);
    chk("t6_tie_who", who, 2'b11);
    chk("t6_tie_gameover", {1'b0, gameover}, 2'd1);
    pulse_reset();

    // reset in the middle of a winner pulse
    apply(1, 7, 0, 0);
    apply(1, MAX, 0, 0);
    chk("t6_prepulse", {1'b0, winner}, 2'd1);
    pulse_reset();
    apply(1, 0, 0, 0);
    chk("t6_post_loser", {1'b0, loser}, 2'd0);
    apply(1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
